pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipelined CPU. It tracks every in-flight register writer in a three-slot scoreboard (EX, MEM, WB), interlocks RAW hazards by freezing PC and IF/ID while inserting bubbles into ID/EX, and flushes wrong-path instructions when a branch or jump resolves in MEM. It sits beside the pipeline registers and drives their write-enable and flush inputs; optional forwarding selects are compiled in by macro.

## Interface
- No parameters; register index width fixed at 5, counters fixed at 16 bits.
- CLK  in  1  pipeline clock; all state updates on rising edge
- RSTn  in  1  asynchronous active-low reset
- id_rs, id_rt  in  5  source fields of the instruction in ID
- id_use_rs, id_use_rt  in  1  instruction in ID actually reads that source
- id_rd  in  5  Rd field in ID
- id_regdst, id_regwr, id_memtoreg  in  1  main-decoder outputs in ID
- m_pcsrc  in  1  branch taken or jump in MEM (M_Jump | M_Zero&M_Branch)
- pc_we  out  1  PC load enable
- ifid_we  out  1  IF/ID load enable
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (all controls 0) into that register
- id_byp_a, id_byp_b  out  1  select W_RegDin instead of busA/busB in ID (FWD_EN only, else 0)
- ex_fwd_a, ex_fwd_b  out  2  EX operand select: 00 register, 01 M_ALUout, 10 W_RegDin (FWD_EN only, else 00)
- stall_cnt, flush_cnt  out  16  saturating event counters

## Operation
- ID destination: dst = id_regdst ? id_rd : id_rt; entry valid only if id_regwr and dst != 0.
- Scoreboard slots E, M, W each hold {valid, dst, memtoreg}. Each edge: W<=M, M<=E, E<=ID entry, or bubble (valid=0) when stalling or flushing.
- Hazard match: used source equals valid slot dst.
- Without FWD_EN: stall when any used source matches E, M or W (register file written at the edge, so a same-cycle ID read sees the old value).
- With FWD_EN: stall only when a used source matches E with memtoreg=1 (load-use). ex_fwd registered from ID: match in E -> 01, else match in M -> 10, else 00. id_byp combinational: match in W -> 1. Youngest match wins.
- Stall: pc_we=0, ifid_we=0, idex_flush=1; scoreboard E<=bubble.
- Flush (m_pcsrc=1): pc_we=1, ifid_we=1, ifid_flush=idex_flush=exmem_flush=1; E<=bubble, M<=bubble, W<=old M (the branch itself). Flush overrides stall; ex_fwd registers cleared.
- Normal: pc_we=ifid_we=1, all flushes 0.
- stall_cnt increments on each stall cycle, flush_cnt on each flush cycle; both hold at 16'hFFFF.

## Timing
- Reset: all slots invalid, ex_fwd_a/b=00, counters 0. Combinational outputs then follow inputs (pc_we=1, ifid_we=1, flushes=m_pcsrc).
- Stall/flush/id_byp are combinational from ID fields, slots and m_pcsrc within the same cycle; ex_fwd valid one cycle after the reader leaves ID.
- RAW without FWD_EN: reader behind a producer by 1 stage stalls 3 cycles, by 2 stalls 2, by 3 stalls 1.
- Load-use with FWD_EN: exactly 1 stall cycle.
- Taken branch/jump: 3 wrong-path instructions discarded, target fetched next cycle.
- Reset asserted mid-stall or mid-flush: state clears immediately; no pending stall survives.

## Configuration
- PPCPU_FWD_EN defined: forwarding outputs active, stalls only for load-use.
- Undefined: id_byp_a/b tied 0, ex_fwd_a/b tied 00, full interlock on E/M/W matches.

## Structure
- Shared package ppcpu_pkg: scoreboard slot struct, FWD_REG/FWD_MEM/FWD_WB encodings, REG_ZERO constant.
- One sub-module: sat_counter16 (increment enable, async reset, saturate), instantiated twice.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 (no FWD_EN) -> 3 stall cycles, stall_cnt=3, sub reads correct $3.
- Same pair with PPCPU_FWD_EN -> 0 stalls, ex_fwd_a=01 when sub in EX.
- lw $3,0($0) then add $4,$3,$3 with PPCPU_FWD_EN -> 1 stall, then ex_fwd_a=ex_fwd_b=10.
- Taken beq with m_pcsrc=1 for one cycle -> all three flushes 1, E/M slots invalid, flush_cnt=1.
- m_pcsrc=1 while a RAW stall is active -> flush wins, pc_we=1, stall_cnt unchanged that cycle.
- Writer to $0 followed by reader of $0 -> no stall; RSTn pulsed mid-stall -> stall drops, counters 0.

Source files
------------

// File: rtl/ppcpu_pkg.sv
// Shared types and encodings for the pipelined CPU hazard logic.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ppcpu_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight register writer tracked by the scoreboard
  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       memtoreg;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A used source hits a slot when the slot is valid and writes that register;
  // load_only further restricts the hit to slots whose result comes from memory.
  function automatic logic slot_hit(slot_t s, logic use_src, logic [4:0] src,
                                    logic load_only);
    return use_src && s.vld && (s.dst == src) && (!load_only || s.memtoreg);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an enabled cycle after the next rising edge.
// Backpressure: none; increments whenever inc_en is high.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  output logic [15:0] cnt
);

  // Count enabled cycles, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (inc_en && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW interlock, branch flush and optional forwarding control for the 5-stage CPU (forwarding under PPCPU_FWD_EN).
// Latency: stall/flush/id_byp combinational same cycle; ex_fwd registered, valid when the reader is in EX.
// Backpressure: a stall freezes PC and IF/ID and bubbles ID/EX; a MEM-resolved branch flushes IF/ID, ID/EX, EX/MEM.
module pipeline_hazard_ctrl
  import ppcpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_regdst,
  input  logic        id_regwr,
  input  logic        id_memtoreg,
  input  logic        m_pcsrc,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        id_byp_a,
  output logic        id_byp_b,
  output logic [1:0]  ex_fwd_a,
  output logic [1:0]  ex_fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  slot_t      id_slot;
  slot_t      e_slot;
  slot_t      m_slot;
  slot_t      w_slot;
  logic [4:0] id_dst;
  logic       hit_e_a, hit_m_a, hit_w_a;
  logic       hit_e_b, hit_m_b, hit_w_b;
  logic       stall_raw;
  logic       flush;
  logic       stall;

  // Build the scoreboard entry for the instruction in ID; writes to $0 are not tracked
  always_comb begin
    id_dst           = id_regdst ? id_rd : id_rt;
    id_slot.vld      = id_regwr && (id_dst != REG_ZERO);
    id_slot.dst      = id_dst;
    id_slot.memtoreg = id_memtoreg;
  end

  assign hit_e_a = slot_hit(e_slot, id_use_rs, id_rs, 1'b0);
  assign hit_m_a = slot_hit(m_slot, id_use_rs, id_rs, 1'b0);
  assign hit_w_a = slot_hit(w_slot, id_use_rs, id_rs, 1'b0);
  assign hit_e_b = slot_hit(e_slot, id_use_rt, id_rt, 1'b0);
  assign hit_m_b = slot_hit(m_slot, id_use_rt, id_rt, 1'b0);
  assign hit_w_b = slot_hit(w_slot, id_use_rt, id_rt, 1'b0);

`ifdef PPCPU_FWD_EN
  // Only a load still in EX cannot be forwarded in time
  assign stall_raw = slot_hit(e_slot, id_use_rs, id_rs, 1'b1) |
                     slot_hit(e_slot, id_use_rt, id_rt, 1'b1);
  // The register file is written at the edge, so a W producer is bypassed in ID
  assign id_byp_a  = hit_w_a;
  assign id_byp_b  = hit_w_b;
`else
  // Any in-flight writer of a used source blocks the read until it has retired
  assign stall_raw = hit_e_a | hit_m_a | hit_w_a | hit_e_b | hit_m_b | hit_w_b;
  assign id_byp_a  = 1'b0;
  assign id_byp_b  = 1'b0;
`endif

  assign flush = m_pcsrc;
  assign stall = stall_raw && !flush;

  // Pipeline-register controls: a flush reloads PC with the target and kills the younger stages
  always_comb begin
    pc_we       = !stall;
    ifid_we     = !stall;
    ifid_flush  = flush;
    idex_flush  = flush || stall_raw;
    exmem_flush = flush;
  end

  // Advance the scoreboard; the branch in M survives into W, younger slots are killed
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      e_slot <= SLOT_BUBBLE;
      m_slot <= SLOT_BUBBLE;
      w_slot <= SLOT_BUBBLE;
    end else begin
      w_slot <= m_slot;
      m_slot <= flush ? SLOT_BUBBLE : e_slot;
      e_slot <= (flush || stall_raw) ? SLOT_BUBBLE : id_slot;
    end
  end

`ifdef PPCPU_FWD_EN
  // Capture EX operand selects as the reader moves to EX; a bubble entering EX gets register selects
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_fwd_a <= FWD_REG;
      ex_fwd_b <= FWD_REG;
    end else if (flush || stall_raw) begin
      ex_fwd_a <= FWD_REG;
      ex_fwd_b <= FWD_REG;
    end else begin
      ex_fwd_a <= hit_e_a ? FWD_MEM : (hit_m_a ? FWD_WB : FWD_REG);
      ex_fwd_b <= hit_e_b ? FWD_MEM : (hit_m_b ? FWD_WB : FWD_REG);
    end
  end
`else
  assign ex_fwd_a = FWD_REG;
  assign ex_fwd_b = FWD_REG;
`endif

  sat_counter16 u_stall_cnt (
    .clk    (CLK),
    .rst_n  (RSTn),
    .inc_en (stall),
    .cnt    (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk    (CLK),
    .rst_n  (RSTn),
    .inc_en (flush),
    .cnt    (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against an age-list reference model (both PPCPU_FWD_EN builds).
// Latency: inputs applied 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

`ifdef PPCPU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_regdst, id_regwr, id_memtoreg;
  logic        m_pcsrc;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
  logic        id_byp_a, id_byp_b;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regdst   (id_regdst),
    .id_regwr    (id_regwr),
    .id_memtoreg (id_memtoreg),
    .m_pcsrc     (m_pcsrc),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .id_byp_a    (id_byp_a),
    .id_byp_b    (id_byp_b),
    .ex_fwd_a    (ex_fwd_a),
    .ex_fwd_b    (ex_fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: list of in-flight writers with their age (1=EX, 2=MEM, 3=WB)
  typedef struct {
    int dst;
    bit mem;
    int age;
  } wr_t;

  wr_t inflight[$];
  int  mdl_fwd_a, mdl_fwd_b;
  int  mdl_stall_cnt, mdl_flush_cnt;

  function automatic bit hit(int src, bit use_src, int age, bit need_load);
    foreach (inflight[i])
      if (use_src && inflight[i].age == age && inflight[i].dst == src &&
          (!need_load || inflight[i].mem))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    inflight.delete();
    mdl_fwd_a = 0;
    mdl_fwd_b = 0;
    mdl_stall_cnt = 0;
    mdl_flush_cnt = 0;
  endtask

  task automatic set_id(input int rs, input int rt, input int rd, input bit urs,
                        input bit urt, input bit regdst, input bit regwr, input bit mem);
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_use_rs = urs; id_use_rt = urt;
    id_regdst = regdst; id_regwr = regwr; id_memtoreg = mem;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock cycle: entered just after a rising edge with ID fields set
  task automatic cycle(input bit pcsrc);
    bit  st_raw, fl, st, byp_a, byp_b;
    int  dst, nfa, nfb;
    wr_t nq[$];
    wr_t nw;
    m_pcsrc = pcsrc;
    #1;
    dst = id_regdst ? int'(id_rd) : int'(id_rt);
    if (FWD) begin
      st_raw = hit(id_rs, id_use_rs, 1, 1'b1) || hit(id_rt, id_use_rt, 1, 1'b1);
    end else begin
      st_raw = 1'b0;
      for (int a = 1; a <= 3; a++)
        st_raw |= hit(id_rs, id_use_rs, a, 1'b0) | hit(id_rt, id_use_rt, a, 1'b0);
    end
    fl    = pcsrc;
    st    = st_raw && !fl;
    byp_a = FWD && hit(id_rs, id_use_rs, 3, 1'b0);
    byp_b = FWD && hit(id_rt, id_use_rt, 3, 1'b0);
    chk("pc_we",       pc_we,       !st);
    chk("ifid_we",     ifid_we,     !st);
    chk("ifid_flush",  ifid_flush,  fl);
    chk("idex_flush",  idex_flush,  fl || st_raw);
    chk("exmem_flush", exmem_flush, fl);
    chk("id_byp_a",    id_byp_a,    byp_a);
    chk("id_byp_b",    id_byp_b,    byp_b);
    chk("ex_fwd_a",    ex_fwd_a,    mdl_fwd_a);
    chk("ex_fwd_b",    ex_fwd_b,    mdl_fwd_b);
    chk("stall_cnt",   stall_cnt,   mdl_stall_cnt);
    chk("flush_cnt",   flush_cnt,   mdl_flush_cnt);
    // Next-state of the model
    nfa = 0; nfb = 0;
    if (FWD && !fl && !st_raw) begin
      nfa = hit(id_rs, id_use_rs, 1, 1'b0) ? 1 : (hit(id_rs, id_use_rs, 2, 1'b0) ? 2 : 0);
      nfb = hit(id_rt, id_use_rt, 1, 1'b0) ? 1 : (hit(id_rt, id_use_rt, 2, 1'b0) ? 2 : 0);
    end
    foreach (inflight[i]) begin
      if (!(fl && inflight[i].age == 1) && inflight[i].age < 3) begin
        nw = inflight[i];
        nw.age++;
        nq.push_back(nw);
      end
    end
    if (!fl && !st_raw && id_regwr && dst != 0) begin
      nw.dst = dst; nw.mem = id_memtoreg; nw.age = 1;
      nq.push_back(nw);
    end
    @(posedge CLK);
    #1;
    inflight = nq;
    mdl_fwd_a = nfa;
    mdl_fwd_b = nfb;
    if (st && mdl_stall_cnt < 65535) mdl_stall_cnt++;
    if (fl && mdl_flush_cnt < 65535) mdl_flush_cnt++;
  endtask

  task automatic pulse_reset();
    RSTn = 1'b0;
    #1;
    model_reset();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn = 1'b0;
    m_pcsrc = 1'b0;
    set_nop();
    model_reset();
    #12;
    chk("reset_pc_we",      pc_we,      1);
    chk("reset_idex_flush", idex_flush, 0);
    chk("reset_ex_fwd_a",   ex_fwd_a,   0);
    chk("reset_stall_cnt",  stall_cnt,  0);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // add $3,$1,$2 then sub $4,$3,$5
    set_id(1, 2, 3, 1, 1, 1, 1, 0); cycle(0);
    set_id(3, 5, 4, 1, 1, 1, 1, 0); cycle(0);
    chk("sub_fwd_a", ex_fwd_a, FWD ? 1 : 0);
    for (int k = 0; k < 5; k++) cycle(0);
    set_nop(); cycle(0);
    chk("raw_stall_total", stall_cnt, FWD ? 0 : 3);

    // lw $3,0($0) then add $4,$3,$3
    pulse_reset();
    set_id(0, 3, 0, 1, 0, 0, 1, 1); cycle(0);
    set_id(3, 3, 4, 1, 1, 1, 1, 0); cycle(0); cycle(0);
    chk("lu_fwd_a", ex_fwd_a, FWD ? 2 : 0);
    chk("lu_fwd_b", ex_fwd_b, FWD ? 2 : 0);
    for (int k = 0; k < 4; k++) cycle(0);
    set_nop(); cycle(0);
    chk("lu_stall_total", stall_cnt, FWD ? 1 : 3);

    // Taken branch with writers $3 in M and $2 in E
    pulse_reset();
    set_id(1, 1, 3, 0, 0, 1, 1, 0); cycle(0);
    set_id(1, 1, 2, 0, 0, 1, 1, 0); cycle(0);
    set_nop(); cycle(1);
    chk("br_flush_cnt", flush_cnt, 1);
    set_id(2, 0, 6, 1, 0, 1, 1, 0);
    #1;
    chk("post_flush_no_stall", pc_we, 1);
    cycle(0);
    set_nop(); cycle(0); cycle(0);

    // Flush arriving during a RAW stall
    pulse_reset();
    set_id(1, 2, 3, 1, 1, 1, 1, 0); cycle(0);
    set_id(3, 5, 4, 1, 1, 1, 1, 0); cycle(0);
    m_pcsrc = 1'b1;
    #1;
    chk("flush_over_stall_pc_we", pc_we, 1);
    cycle(1);
    chk("flush_over_stall_cnt", stall_cnt, FWD ? 0 : 1);
    set_nop(); cycle(0); cycle(0);

    // Writer to $0 followed by a reader of $0
    set_id(1, 2, 0, 1, 1, 1, 1, 0); cycle(0);
    set_id(0, 0, 5, 1, 1, 1, 1, 0);
    #1;
    chk("zero_reg_no_stall", pc_we, 1);
    cycle(0);
    set_nop(); cycle(0);

    // Reset pulsed in the middle of a load-use stall
    set_id(0, 3, 0, 1, 0, 0, 1, 1); cycle(0);
    set_id(3, 3, 4, 1, 1, 1, 1, 0); cycle(0);
    RSTn = 1'b0;
    #1;
    chk("midrst_pc_we",      pc_we,      1);
    chk("midrst_idex_flush", idex_flush, 0);
    chk("midrst_stall_cnt",  stall_cnt,  0);
    chk("midrst_flush_cnt",  flush_cnt,  0);
    chk("midrst_ex_fwd_a",   ex_fwd_a,   0);
    RSTn = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    cycle(0);
    set_nop(); cycle(0);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle($urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
